// File: rtl/wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_arbiter_pkg
// Shared types for the write-back arbitration path: functional-unit encoding,
// the write-back payload type, requester count and the source index enum.
// No ports (package).
// -----------------------------------------------------------------------------
package wb_arbiter_pkg;

    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_LSU  = 2'd1,
        FU_MFPU = 2'd2
    } fu_e;

    // Packed as {rd_wen, rd[4:0], rd_wdata[31:0]} (38 bits).
    typedef struct packed {
        logic        rd_wen;
        logic [4:0]  rd;
        logic [31:0] rd_wdata;
    } wb_req_t;

    localparam int unsigned WB_NUM_REQ = 3;

    typedef enum logic [1:0] {
        WB_SRC_ALU  = 2'd0,
        WB_SRC_LSU  = 2'd1,
        WB_SRC_MFPU = 2'd2
    } wb_src_e;

    // Index width that stays at least one bit for a single requester.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Writes to x0 are architecturally void; keep rd/data for tracing.
    function automatic wb_req_t wb_squash_x0(input wb_req_t r);
        wb_req_t o;
        o = r;
        if (r.rd == 5'd0) begin
            o.rd_wen = 1'b0;
        end
        return o;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_arbiter_if
// Bundles the requester handshakes and the write-back slot signals.
//   req_valid_i [NUM_REQ]  per-requester valid
//   req_i       [NUM_REQ]  per-requester wb_req_t payload
//   req_ready_o [NUM_REQ]  per-requester grant
//   wb_valid_o             write-back slot holds a result
//   wb_o                   registered write-back payload
//   wb_src_o               index of the requester that produced wb_o
//   wb_ready_i             consumer accepts the slot this cycle
// Modports: slave = arbiter side, master = requester/consumer side.
// -----------------------------------------------------------------------------
interface wb_arbiter_if
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = WB_NUM_REQ,
    parameter int unsigned SRC_W   = idx_w(NUM_REQ)
);

    logic    [NUM_REQ-1:0] req_valid_i;
    wb_req_t [NUM_REQ-1:0] req_i;
    logic    [NUM_REQ-1:0] req_ready_o;
    logic                  wb_valid_o;
    wb_req_t               wb_o;
    logic    [SRC_W-1:0]   wb_src_o;
    logic                  wb_ready_i;

    modport slave (
        input  req_valid_i, req_i, wb_ready_i,
        output req_ready_o, wb_valid_o, wb_o, wb_src_o
    );

    modport master (
        output req_valid_i, req_i, wb_ready_i,
        input  req_ready_o, wb_valid_o, wb_o, wb_src_o
    );

endinterface

// File: rtl/wb_arbiter_rr_grant.sv
// -----------------------------------------------------------------------------
// rr_grant
// Combinational round-robin picker. Searches req_i starting one past
// last_grant_i, wrapping, and grants the first set bit.
//   req_i         [N]      request vector
//   last_grant_i  [IDX_W]  index granted most recently
//   enable_i               when low no grant is issued
//   grant_o       [N]      one-hot grant (all zero when nothing granted)
//   grant_idx_o   [IDX_W]  index of the granted requester
//   grant_valid_o          a grant was issued
// -----------------------------------------------------------------------------
module rr_grant
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned N     = WB_NUM_REQ,
    parameter int unsigned IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    input  logic             enable_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_valid_o
);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = '0;
        if (enable_i) begin
            // Offsets 1..N visit every requester once, the previous
            // winner last.
            for (int unsigned off = 1; off <= N; off++) begin
                cand = IDX_W'((32'(last_grant_i) + off) % N);
                if (!found && req_i[cand]) begin
                    found         = 1'b1;
                    grant_o[cand] = 1'b1;
                    grant_idx_o   = cand;
                end
            end
        end
        grant_valid_o = found;
    end

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Shares the single register-file write port among ALU (0), LSU (1) and
// MFPU (2). One request per cycle is granted round-robin and registered
// into a single write-back slot; writes to x0 have rd_wen cleared.
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   bus             wb_arbiter_if.slave: requester handshakes + wb slot
//   conflict_cnt_o  saturating count of cycles with >=2 requesters
//                   contending for a free slot
// -----------------------------------------------------------------------------
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = WB_NUM_REQ,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_arbiter_if.slave      bus,
    output logic [CNT_W-1:0] conflict_cnt_o
);

    localparam int unsigned SRC_W = idx_w(NUM_REQ);

    logic               slot_free;
    logic [NUM_REQ-1:0] grant;
    logic [SRC_W-1:0]   grant_idx;
    logic               grant_valid;

    logic               wb_valid_q, wb_valid_d;
    wb_req_t            wb_q, wb_d;
    logic [SRC_W-1:0]   wb_src_q, wb_src_d;
    logic [SRC_W-1:0]   last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Draining and refilling in the same cycle is allowed, so the slot
    // counts as free whenever the consumer takes it.
    assign slot_free = !wb_valid_q || bus.wb_ready_i;

    rr_grant #(
        .N     (NUM_REQ),
        .IDX_W (SRC_W)
    ) u_rr_grant (
        .req_i         (bus.req_valid_i),
        .last_grant_i  (last_grant_q),
        .enable_i      (slot_free),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    assign bus.req_ready_o = grant;
    assign bus.wb_valid_o  = wb_valid_q;
    assign bus.wb_o        = wb_q;
    assign bus.wb_src_o    = wb_src_q;
    assign conflict_cnt_o  = cnt_q;

    always_comb begin
        wb_valid_d   = wb_valid_q;
        wb_d         = wb_q;
        wb_src_d     = wb_src_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;

        if (grant_valid) begin
            wb_valid_d   = 1'b1;
            wb_d         = wb_squash_x0(bus.req_i[grant_idx]);
            wb_src_d     = grant_idx;
            last_grant_d = grant_idx;
        end else if (slot_free) begin
            // Payload left as-is: it is don't-care once valid drops.
            wb_valid_d = 1'b0;
        end

        if (slot_free && ($countones(bus.req_valid_i) >= 2) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q   <= 1'b0;
            wb_q         <= '0;
            wb_src_q     <= '0;
            last_grant_q <= SRC_W'(NUM_REQ - 1);
            cnt_q        <= '0;
        end else begin
            wb_valid_q   <= wb_valid_d;
            wb_q         <= wb_d;
            wb_src_q     <= wb_src_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Directed and randomized bench for wb_arbiter against a transaction-level
// reference model of the round-robin write-back slot.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int N       = 3;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [CNT_W-1:0] cnt;

    wb_arbiter_if #(.NUM_REQ(N)) bus ();

    wb_arbiter #(
        .NUM_REQ (N),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus.slave),
        .conflict_cnt_o (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int       m_last;
    bit       m_valid;
    wb_req_t  m_wb;
    int       m_src;
    int       m_cnt;
    int       last_g;
    logic [N-1:0] rdy_seen;

    // Stimulus state
    bit [N-1:0] pend;
    wb_req_t    pay [N];
    bit         rule_en;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // First valid requester after 'last', wrapping; -1 if none.
    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last  = N - 1;
        m_valid = 1'b0;
        m_wb    = '0;
        m_src   = 0;
        m_cnt   = 0;
    endtask

    task automatic drive(input logic [N-1:0] v);
        bus.req_valid_i = v;
        for (int i = 0; i < N; i++) bus.req_i[i] = pay[i];
    endtask

    task automatic rand_pay(input int i, input bit nonzero_rd);
        pay[i].rd_wen   = 1'($urandom);
        pay[i].rd       = nonzero_rd ? 5'($urandom_range(1, 31)) : 5'($urandom);
        pay[i].rd_wdata = $urandom;
    endtask

    // Called at posedge+1 with inputs already driven; returns at next posedge+1.
    task automatic do_cycle(input string tag);
        bit           free;
        int           g;
        logic [N-1:0] exp_rdy;
        wb_req_t      nxt;
        #3;
        free    = !m_valid || bus.wb_ready_i;
        g       = free ? pick(bus.req_valid_i, m_last) : -1;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        rdy_seen = bus.req_ready_o;
        chk({tag, ".ready"}, 64'(bus.req_ready_o), 64'(exp_rdy));
        if (free && ($countones(bus.req_valid_i) >= 2) && (m_cnt < CNT_MAX)) m_cnt++;
        if (g >= 0) begin
            nxt = bus.req_i[g];
            if (nxt.rd == 5'd0) nxt.rd_wen = 1'b0;
            m_wb    = nxt;
            m_src   = g;
            m_valid = 1'b1;
            m_last  = g;
        end else if (free) begin
            m_valid = 1'b0;
        end
        last_g = g;
        @(posedge clk);
        #1;
        chk({tag, ".wb_valid"}, 64'(bus.wb_valid_o), 64'(m_valid));
        if (m_valid) begin
            chk({tag, ".wb"}, 64'(bus.wb_o), 64'(m_wb));
            chk({tag, ".wb_src"}, 64'(bus.wb_src_o), 64'(m_src));
        end
        chk({tag, ".cnt"}, 64'(cnt), 64'(m_cnt));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".wb_valid"}, 64'(bus.wb_valid_o), 64'(0));
        chk({tag, ".wb"}, 64'(bus.wb_o), 64'(0));
        chk({tag, ".wb_src"}, 64'(bus.wb_src_o), 64'(0));
        chk({tag, ".cnt"}, 64'(cnt), 64'(0));
    endtask

    task automatic do_reset();
        logic [N-1:0] exp_rdy;
        int           g;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) rand_pay(i, 1'b0);
        drive(N'($urandom));
        bus.wb_ready_i = 1'($urandom);
        #2;
        chk_reset_outputs("rst.async");
        @(posedge clk);
        #1;
        chk_reset_outputs("rst.hold");
        // Empty slot during reset: priority search starts at requester 0.
        g = pick(bus.req_valid_i, N - 1);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("rst.ready", 64'(bus.req_ready_o), 64'(exp_rdy));
        bus.req_valid_i = '0;
        bus.wb_ready_i  = 1'b1;
        #2;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    // Requesters must hold valid and payload until handshake.
    bit [N-1:0] wait_q;
    wb_req_t    held [N];
    always @(negedge clk) begin
        if (!rule_en) begin
            wait_q = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wait_q[i]) begin
                    chk("rule.hold", 64'({bus.req_valid_i[i], bus.req_i[i]}),
                        64'({1'b1, held[i]}));
                end
                wait_q[i] = bus.req_valid_i[i] && !bus.req_ready_o[i];
                held[i]   = bus.req_i[i];
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        bus.req_valid_i = '0;
        bus.req_i       = '0;
        bus.wb_ready_i  = 1'b0;
        pend            = '0;
        rule_en         = 1'b0;
        last_g          = -1;
        rdy_seen        = '0;
        for (int i = 0; i < N; i++) pay[i] = '0;
        model_reset();

        // Reset, then a single ALU request
        do_reset();
        pay[0] = '{rd_wen: 1'b1, rd: 5'd5, rd_wdata: 32'hDEADBEEF};
        bus.wb_ready_i = 1'b1;
        drive(3'b001);
        do_cycle("t2.req");
        chk("t2.ready0", 64'(rdy_seen), 64'(3'b001));
        chk("t2.valid1", 64'(bus.wb_valid_o), 64'(1));
        chk("t2.payload", 64'(bus.wb_o), 64'({1'b1, 5'd5, 32'hDEADBEEF}));
        chk("t2.src", 64'(bus.wb_src_o), 64'(WB_SRC_ALU));
        drive(3'b000);
        do_cycle("t2.drain");
        chk("t2.valid2", 64'(bus.wb_valid_o), 64'(0));

        // Full contention from a fresh reset
        do_reset();
        for (int i = 0; i < N; i++) rand_pay(i, 1'b1);
        drive(3'b111);
        for (int k = 0; k < 6; k++) begin
            do_cycle("t3.cont");
            chk("t3.order", 64'(rdy_seen), 64'(1 << (k % 3)));
            chk("t3.valid", 64'(bus.wb_valid_o), 64'(1));
        end
        chk("t3.cnt6", 64'(cnt), 64'(6));
        drive(3'b000);
        do_cycle("t3.drain");

        // x0 write from the LSU
        pay[1] = '{rd_wen: 1'b1, rd: 5'd0, rd_wdata: 32'h12345678};
        drive(3'b010);
        do_cycle("t4.x0");
        chk("t4.payload", 64'(bus.wb_o), 64'({1'b0, 5'd0, 32'h12345678}));
        chk("t4.src", 64'(bus.wb_src_o), 64'(WB_SRC_LSU));

        // Backpressure
        pay[0] = '{rd_wen: 1'b1, rd: 5'd7, rd_wdata: 32'hA5A50001};
        drive(3'b001);
        do_cycle("t5.setup");
        rand_pay(1, 1'b1);
        rand_pay(2, 1'b1);
        drive(3'b110);
        bus.wb_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            do_cycle("t5.stall");
            chk("t5.noready", 64'(rdy_seen), 64'(0));
            chk("t5.stable", 64'(bus.wb_o), 64'({1'b1, 5'd7, 32'hA5A50001}));
            chk("t5.cnt", 64'(cnt), 64'(6));
        end
        bus.wb_ready_i = 1'b1;
        do_cycle("t5.rel1");
        chk("t5.lsu_first", 64'(rdy_seen), 64'(3'b010));
        chk("t5.src_lsu", 64'(bus.wb_src_o), 64'(WB_SRC_LSU));
        drive(3'b100);
        do_cycle("t5.rel2");
        chk("t5.mfpu_next", 64'(rdy_seen), 64'(3'b100));
        chk("t5.src_mfpu", 64'(bus.wb_src_o), 64'(WB_SRC_MFPU));
        drive(3'b000);
        do_cycle("t5.drain");

        // Randomized traffic under the requester hold rule
        pend    = '0;
        rule_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
                    rand_pay(i, 1'b0);
                    pend[i] = 1'b1;
                end
            end
            bus.wb_ready_i = ($urandom_range(0, 3) != 0);
            drive(pend);
            do_cycle("rand");
            if (last_g >= 0) pend[last_g] = 1'b0;
        end
        rule_en = 1'b0;

        // Saturation, then asynchronous reset between edges
        do_reset();
        for (int i = 0; i < N; i++) rand_pay(i, 1'b0);
        drive(3'b111);
        bus.wb_ready_i = 1'b1;
        for (int k = 0; k < 20; k++) do_cycle("t6.sat");
        chk("t6.cnt_sat", 64'(cnt), 64'(4'hF));
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6.async");
        model_reset();
        drive(3'b000);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(3'b101);
        do_cycle("t6.after");
        chk("t6.first_prio", 64'(rdy_seen), 64'(3'b001));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
